lut_target_encoder: RTL and testbench

Reverse-lookup engine for the branch-target table: given a full 10-bit PC target offset, it finds the table index (the short pointer carried in the instruction) whose entry equals that offset. It holds a writable copy of the target table, scans it sequentially under a valid/ready handshake, and reports hit/index. It sits between the program loader/assembler-check path and the fetch-side target table, which consumes the same index-to-offset mapping in the forward direction.

---
 rtl/lut_target_encoder.sv | 102 ++++++++++
 tb/tb_lut_target_encoder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/lut_target_encoder.sv
// lut_target_encoder: reverse lookup of a target offset to its table index; define LUT_ALLOC_EN to allocate entries on a miss
module lut_target_encoder #(
    parameter int ENTRIES = 4,
    parameter int IW      = 2,
    parameter int TW      = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          WrEn,
    input  logic [IW-1:0] WrAddr,
    input  logic [TW-1:0] WrData,
    input  logic          ReqValid,
    input  logic [TW-1:0] ReqTarget,
    output logic          ReqReady,
    output logic          RespValid,
    input  logic          RespReady,
    output logic          RespHit,
    output logic [IW-1:0] RespIndex,
    output logic          Busy
);
    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
    state_t        state, state_n;
    logic [TW-1:0] tbl [ENTRIES];
    logic [TW-1:0] tgt, tgt_n;
    logic [IW-1:0] ptr, ptr_n, idx_n, miss_idx;
    logic          hit_n, match, last, scan_miss;
`ifdef LUT_ALLOC_EN
    logic [IW-1:0] alloc_ptr;
    assign miss_idx = alloc_ptr;
`else
    assign miss_idx = '0;
`endif
    assign match     = tbl[ptr] == tgt;
    assign last      = ptr == IW'(ENTRIES - 1);
    assign scan_miss = state == SCAN && !match && last;
    assign ReqReady  = state == IDLE;
    assign RespValid = state == RESP;
    assign Busy      = state != IDLE;
    // table storage: reset image, allocation on a miss, external writes take priority
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl[i] <= i == 0 ? {TW{1'b1}} : i == 1 ? TW'(3) : i == 2 ? TW'(7) : TW'(1);
        end else begin
`ifdef LUT_ALLOC_EN
            if (scan_miss) tbl[alloc_ptr] <= tgt;
`endif
            if (WrEn) tbl[WrAddr] <= WrData;
        end
    end
`ifdef LUT_ALLOC_EN
    // round-robin allocation pointer, advances on every miss
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) alloc_ptr <= '0;
        else if (scan_miss) alloc_ptr <= alloc_ptr + IW'(1);
    end
`endif
    // FSM and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            tgt       <= '0;
            ptr       <= '0;
            RespHit   <= 1'b0;
            RespIndex <= '0;
        end else begin
            state     <= state_n;
            tgt       <= tgt_n;
            ptr       <= ptr_n;
            RespHit   <= hit_n;
            RespIndex <= idx_n;
        end
    end
    // next state: capture request, scan ascending, hold result until accepted
    always_comb begin
        state_n = state;
        tgt_n   = tgt;
        ptr_n   = ptr;
        hit_n   = RespHit;
        idx_n   = RespIndex;
        case (state)
            IDLE: if (ReqValid) begin
                tgt_n   = ReqTarget;
                ptr_n   = '0;
                state_n = SCAN;
            end
            SCAN: if (match) begin
                hit_n   = 1'b1;
                idx_n   = ptr;
                state_n = RESP;
            end else if (last) begin
                hit_n   = 1'b0;
                idx_n   = miss_idx;
                state_n = RESP;
            end else begin
                ptr_n = ptr + IW'(1);
            end
            RESP: if (RespReady) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lut_target_encoder.sv
// tb_lut_target_encoder: directed checks of lookup results, latency, backpressure, collisions and reset
module tb_lut_target_encoder;
    logic       Clk = 0, Reset = 1, WrEn = 0, ReqValid = 0, RespReady = 1;
    logic [1:0] WrAddr = 0;
    logic [9:0] WrData = 0, ReqTarget = 0;
    logic       ReqReady, RespValid, RespHit, Busy;
    logic [1:0] RespIndex;
    int         n_checks = 0, n_fail = 0;

    lut_target_encoder dut (
        .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .ReqValid(ReqValid), .ReqTarget(ReqTarget), .ReqReady(ReqReady),
        .RespValid(RespValid), .RespReady(RespReady), .RespHit(RespHit),
        .RespIndex(RespIndex), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [9:0] d);
        WrEn = 1; WrAddr = a; WrData = d;
        @(posedge Clk); #1;
        WrEn = 0;
    endtask

    task automatic start_req(input logic [9:0] t);
        ReqValid = 1; ReqTarget = t;
        @(posedge Clk); #1;
        ReqValid = 0;
    endtask

    task automatic wait_resp(output int k);
        k = 0;
        while (!RespValid && k < 20) begin
            @(posedge Clk); #1;
            k++;
        end
    endtask

    task automatic lookup(input string tag, input logic [9:0] t, input logic eh,
                          input logic [1:0] ei, input int lat);
        int k;
        start_req(t);
        check({tag, "_busy"}, Busy, 1);
        wait_resp(k);
        check({tag, "_lat"}, k, lat);
        check({tag, "_hit"}, RespHit, eh);
        check({tag, "_idx"}, RespIndex, ei);
        @(posedge Clk); #1;
        check({tag, "_done"}, {RespValid, ReqReady}, 2'b01);
    endtask

    initial begin
        int k;
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 0;
        check("rst_ready", ReqReady, 1);
        check("rst_valid", RespValid, 0);
        check("rst_hit", RespHit, 0);
        check("rst_idx", RespIndex, 0);
        check("rst_busy", Busy, 0);

        lookup("h007", 10'h007, 1, 2, 3);
        lookup("h3ff", 10'h3FF, 1, 0, 1);
        lookup("h001", 10'h001, 1, 3, 4);
        wr(1, 10'h001);
        lookup("dup", 10'h001, 1, 1, 2);
        lookup("miss1", 10'h055, 0, 0, 4);
`ifdef LUT_ALLOC_EN
        lookup("alloc_hit", 10'h055, 1, 0, 1);
        lookup("miss2", 10'h0AA, 0, 1, 4);
`else
        lookup("miss_again", 10'h055, 0, 0, 4);
        lookup("unchanged", 10'h3FF, 1, 0, 1);
`endif

        RespReady = 0;
        start_req(10'h007);
        wait_resp(k);
        check("bp_lat", k, 3);
        ReqValid = 1; ReqTarget = 10'h3FF;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            check("bp_hold", {RespValid, RespHit, RespIndex, ReqReady}, 5'b11100);
        end
        ReqValid = 0; RespReady = 1;
        @(posedge Clk); #1;
        check("bp_release", {RespValid, ReqReady, Busy}, 3'b010);

        wr(1, 10'h003);
        start_req(10'h003);
        @(posedge Clk); #1;
        WrEn = 1; WrAddr = 1; WrData = 10'h100;
        @(posedge Clk); #1;
        WrEn = 0;
        check("coll_valid", RespValid, 1);
        check("coll_hit", RespHit, 1);
        check("coll_idx", RespIndex, 1);
        @(posedge Clk); #1;
        lookup("new100", 10'h100, 1, 1, 2);

        wr(2, 10'h200);
        start_req(10'h007);
        Reset = 1; #1;
        check("mid_rst", {RespValid, ReqReady, Busy}, 3'b010);
        @(posedge Clk); #1;
        Reset = 0;
        lookup("restored", 10'h007, 1, 2, 3);
        lookup("restored0", 10'h3FF, 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
